// File: rtl/reqrsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reqrsp_pkg
//  Purpose  : Shared types for the reqrsp bus: atomic opcode enum, access
//             size, default-width payload structs, spill-register state
//             encoding and payload width helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package reqrsp_pkg;

  localparam int unsigned AmoWidth     = 4;
  localparam int unsigned SizeWidth    = 2;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic [AmoWidth-1:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  // log2 of the access size in bytes
  typedef logic [SizeWidth-1:0] size_t;

  // Payload structs at the default widths. The field order matches the
  // flattened word used by the cut, so they can be overlaid on it.
  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      write;
    amo_op_e                   amo;
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    size_t                     size;
  } req_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic                    error;
  } rsp_t;

  // Occupancy of a two-slot spill register
  typedef enum logic [1:0] {
    SpillEmpty = 2'd0,
    SpillOne   = 2'd1,
    SpillFull  = 2'd2
  } spill_state_e;

  function automatic int unsigned req_width(int unsigned addr_w, int unsigned data_w);
    return addr_w + 1 + AmoWidth + data_w + data_w / 8 + SizeWidth;
  endfunction

  function automatic int unsigned rsp_width(int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reqrsp_spill_reg.sv
`default_nettype none
// ============================================================================
//  Module   : reqrsp_spill_reg
//  Purpose  : Generic two-slot spill register (slots A and B) with FIFO
//             order and full throughput. in_ready and out_valid are decoded
//             purely from the state flops, so no combinational path joins
//             the two sides. With Bypass=1 it degenerates to wires.
//  Ports    : clk, rst_n (async, active-high)
//             in_data/in_valid/in_ready    - upstream side
//             out_data/out_valid/out_ready - downstream side
//  Revision : 1.0 - initial release
// ============================================================================
module reqrsp_spill_reg
  import reqrsp_pkg::*;
#(
  parameter int unsigned Width  = 8,
  parameter bit          Bypass = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  if (Bypass) begin : g_bypass

    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

  end else begin : g_reg

    spill_state_e     state_q, state_d;
    logic [Width-1:0] a_q, a_d;   // head slot, always drives the output
    logic [Width-1:0] b_q, b_d;   // overflow slot, used only when FULL

    always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
        SpillEmpty: begin
          if (in_valid) begin
            a_d     = in_data;
            state_d = SpillOne;
          end
        end
        SpillOne: begin
          if (in_valid && out_ready) begin
            // head leaves while the new beat takes its place
            a_d = in_data;
          end else if (in_valid) begin
            b_d     = in_data;
            state_d = SpillFull;
          end else if (out_ready) begin
            state_d = SpillEmpty;
          end
        end
        SpillFull: begin
          // in_ready is low here, so only a pop can happen
          if (out_ready) begin
            a_d     = b_q;
            state_d = SpillOne;
          end
        end
        default: state_d = SpillEmpty;
      endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        state_q <= SpillEmpty;
        a_q     <= '0;
        b_q     <= '0;
      end else begin
        state_q <= state_d;
        a_q     <= a_d;
        b_q     <= b_d;
      end
    end

    assign in_ready  = (state_q != SpillFull);
    assign out_valid = (state_q != SpillEmpty);
    assign out_data  = a_q;

  end

endmodule
`default_nettype wire

// File: rtl/reqrsp_cut.sv
`default_nettype none
// ============================================================================
//  Module   : reqrsp_cut
//  Purpose  : Timing cut for a reqrsp bus. Independent spill registers on
//             the request (q) and response (p) channels; only handshake
//             timing changes, payload/order/count are preserved.
//  Ports    : clk, rst_n (async, active-high)
//             slv_q_* / slv_p_* - toward the reqrsp master
//             mst_q_* / mst_p_* - toward the reqrsp slave
//  Config   : define REQRSP_CUT_ASSERT_EN to enable handshake protocol
//             assertions on all four interfaces.
//  Revision : 1.0 - initial release
// ============================================================================
module reqrsp_cut
  import reqrsp_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter bit          BypassReq = 1'b0,
  parameter bit          BypassRsp = 1'b0,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // master side
  input  logic [AddrWidth-1:0] slv_q_addr,
  input  logic                 slv_q_write,
  input  logic [AmoWidth-1:0]  slv_q_amo,
  input  logic [DataWidth-1:0] slv_q_data,
  input  logic [StrbWidth-1:0] slv_q_strb,
  input  logic [SizeWidth-1:0] slv_q_size,
  input  logic                 slv_q_valid,
  output logic                 slv_q_ready,
  output logic [DataWidth-1:0] slv_p_data,
  output logic                 slv_p_error,
  output logic                 slv_p_valid,
  input  logic                 slv_p_ready,
  // slave side
  output logic [AddrWidth-1:0] mst_q_addr,
  output logic                 mst_q_write,
  output logic [AmoWidth-1:0]  mst_q_amo,
  output logic [DataWidth-1:0] mst_q_data,
  output logic [StrbWidth-1:0] mst_q_strb,
  output logic [SizeWidth-1:0] mst_q_size,
  output logic                 mst_q_valid,
  input  logic                 mst_q_ready,
  input  logic [DataWidth-1:0] mst_p_data,
  input  logic                 mst_p_error,
  input  logic                 mst_p_valid,
  output logic                 mst_p_ready
);

  localparam int unsigned ReqWidth = req_width(AddrWidth, DataWidth);
  localparam int unsigned RspWidth = rsp_width(DataWidth);

  logic [ReqWidth-1:0] req_in, req_out;
  logic [RspWidth-1:0] rsp_in, rsp_out;

  assign req_in = {slv_q_addr, slv_q_write, slv_q_amo, slv_q_data, slv_q_strb, slv_q_size};
  assign {mst_q_addr, mst_q_write, mst_q_amo, mst_q_data, mst_q_strb, mst_q_size} = req_out;

  assign rsp_in = {mst_p_data, mst_p_error};
  assign {slv_p_data, slv_p_error} = rsp_out;

  reqrsp_spill_reg #(
    .Width  (ReqWidth),
    .Bypass (BypassReq)
  ) u_req_spill (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (req_in),
    .in_valid  (slv_q_valid),
    .in_ready  (slv_q_ready),
    .out_data  (req_out),
    .out_valid (mst_q_valid),
    .out_ready (mst_q_ready)
  );

  reqrsp_spill_reg #(
    .Width  (RspWidth),
    .Bypass (BypassRsp)
  ) u_rsp_spill (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rsp_in),
    .in_valid  (mst_p_valid),
    .in_ready  (mst_p_ready),
    .out_data  (rsp_out),
    .out_valid (slv_p_valid),
    .out_ready (slv_p_ready)
  );

`ifdef REQRSP_CUT_ASSERT_EN
  property p_valid_hold(v, r);
    @(posedge clk) disable iff (rst_n) (v && !r) |=> v;
  endproperty

  property p_data_hold(v, r, d);
    @(posedge clk) disable iff (rst_n) (v && !r) |=> $stable(d);
  endproperty

  property p_valid_known(v);
    @(posedge clk) disable iff (rst_n) !$isunknown(v);
  endproperty

  a_slv_q_valid : assert property (p_valid_hold(slv_q_valid, slv_q_ready));
  a_slv_q_data  : assert property (p_data_hold(slv_q_valid, slv_q_ready, req_in));
  a_mst_q_valid : assert property (p_valid_hold(mst_q_valid, mst_q_ready));
  a_mst_q_data  : assert property (p_data_hold(mst_q_valid, mst_q_ready, req_out));
  a_mst_p_valid : assert property (p_valid_hold(mst_p_valid, mst_p_ready));
  a_mst_p_data  : assert property (p_data_hold(mst_p_valid, mst_p_ready, rsp_in));
  a_slv_p_valid : assert property (p_valid_hold(slv_p_valid, slv_p_ready));
  a_slv_p_data  : assert property (p_data_hold(slv_p_valid, slv_p_ready, rsp_out));

  a_slv_q_vknown : assert property (p_valid_known(slv_q_valid));
  a_mst_q_vknown : assert property (p_valid_known(mst_q_valid));
  a_mst_p_vknown : assert property (p_valid_known(mst_p_valid));
  a_slv_p_vknown : assert property (p_valid_known(slv_p_valid));
`else
  // Protocol assertions not built; datapath is identical either way.
`endif

endmodule
`default_nettype wire

// File: tb/tb_reqrsp_cut.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reqrsp_cut
//  Purpose  : Directed self-checking bench for reqrsp_cut (default widths,
//             no bypass): reset, single write, back-pressure, streaming,
//             response path, async reset mid-flight, and a mixed-traffic
//             queue scoreboard on both channels.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reqrsp_cut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] slv_q_addr;
  logic        slv_q_write;
  logic [3:0]  slv_q_amo;
  logic [31:0] slv_q_data;
  logic [3:0]  slv_q_strb;
  logic [1:0]  slv_q_size;
  logic        slv_q_valid;
  logic        slv_q_ready;
  logic [31:0] slv_p_data;
  logic        slv_p_error;
  logic        slv_p_valid;
  logic        slv_p_ready;
  logic [31:0] mst_q_addr;
  logic        mst_q_write;
  logic [3:0]  mst_q_amo;
  logic [31:0] mst_q_data;
  logic [3:0]  mst_q_strb;
  logic [1:0]  mst_q_size;
  logic        mst_q_valid;
  logic        mst_q_ready;
  logic [31:0] mst_p_data;
  logic        mst_p_error;
  logic        mst_p_valid;
  logic        mst_p_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reqrsp_cut dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slv_q_addr  (slv_q_addr),
    .slv_q_write (slv_q_write),
    .slv_q_amo   (slv_q_amo),
    .slv_q_data  (slv_q_data),
    .slv_q_strb  (slv_q_strb),
    .slv_q_size  (slv_q_size),
    .slv_q_valid (slv_q_valid),
    .slv_q_ready (slv_q_ready),
    .slv_p_data  (slv_p_data),
    .slv_p_error (slv_p_error),
    .slv_p_valid (slv_p_valid),
    .slv_p_ready (slv_p_ready),
    .mst_q_addr  (mst_q_addr),
    .mst_q_write (mst_q_write),
    .mst_q_amo   (mst_q_amo),
    .mst_q_data  (mst_q_data),
    .mst_q_strb  (mst_q_strb),
    .mst_q_size  (mst_q_size),
    .mst_q_valid (mst_q_valid),
    .mst_q_ready (mst_q_ready),
    .mst_p_data  (mst_p_data),
    .mst_p_error (mst_p_error),
    .mst_p_valid (mst_p_valid),
    .mst_p_ready (mst_p_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q_exp[$];
  logic [32:0] p_exp[$];
  bit          q_acc, q_out, p_acc, p_out;
  logic [63:0] q_front;
  logic [32:0] p_front;

  initial begin
    rst_n       = 1'b1;
    slv_q_addr  = '0; slv_q_write = 1'b0; slv_q_amo = '0; slv_q_data = '0;
    slv_q_strb  = '0; slv_q_size  = '0;   slv_q_valid = 1'b0;
    slv_p_ready = 1'b0;
    mst_q_ready = 1'b0;
    mst_p_data  = '0; mst_p_error = 1'b0; mst_p_valid = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_mst_q_valid", mst_q_valid, 1'b0);
    chk("rst_slv_p_valid", slv_p_valid, 1'b0);
    chk("rst_slv_q_ready", slv_q_ready, 1'b1);
    chk("rst_mst_p_ready", mst_p_ready, 1'b1);
    chk("rst_mst_q_addr",  mst_q_addr,  32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    tick();

    // ---------------- single write ----------------
    mst_q_ready = 1'b1;
    slv_q_addr  = 32'h10; slv_q_write = 1'b1; slv_q_amo = 4'h2;
    slv_q_data  = 32'hDEAD_BEEF; slv_q_strb = 4'hF; slv_q_size = 2'd2;
    slv_q_valid = 1'b1;
    #1;
    chk("wr_no_comb_path", mst_q_valid, 1'b0);
    tick();
    slv_q_valid = 1'b0;
    chk("wr_valid", mst_q_valid, 1'b1);
    chk("wr_addr",  mst_q_addr,  32'h10);
    chk("wr_data",  mst_q_data,  32'hDEAD_BEEF);
    chk("wr_strb",  mst_q_strb,  4'hF);
    chk("wr_write", mst_q_write, 1'b1);
    chk("wr_amo",   mst_q_amo,   4'h2);
    chk("wr_size",  mst_q_size,  2'd2);
    tick();
    chk("wr_drained", mst_q_valid, 1'b0);

    // ---------------- back-pressure ----------------
    mst_q_ready = 1'b0;
    slv_q_write = 1'b0; slv_q_amo = 4'h0;
    slv_q_valid = 1'b1; slv_q_addr = 32'h100;
    tick();                                   // A0 accepted -> ONE
    chk("bp_ready_one", slv_q_ready, 1'b1);
    slv_q_addr = 32'h104;
    tick();                                   // A1 accepted -> FULL
    chk("bp_ready_full", slv_q_ready, 1'b0);
    slv_q_addr = 32'h108;
    tick();                                   // A2 refused
    chk("bp_still_full", slv_q_ready, 1'b0);
    chk("bp_hold_addr",  mst_q_addr,  32'h100);
    chk("bp_hold_valid", mst_q_valid, 1'b1);
    mst_q_ready = 1'b1;
    tick();                                   // A0 out, A2 still refused
    chk("bp_order1", mst_q_addr, 32'h104);
    chk("bp_ready_back", slv_q_ready, 1'b1);
    tick();                                   // A1 out, A2 in
    slv_q_valid = 1'b0;
    chk("bp_order2", mst_q_addr, 32'h108);
    chk("bp_order2_v", mst_q_valid, 1'b1);
    tick();
    chk("bp_empty", mst_q_valid, 1'b0);

    // ---------------- streaming ----------------
    mst_q_ready = 1'b1;
    slv_q_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      slv_q_addr = 32'h1000 + i;
      slv_q_data = ~(32'h1000 + i);
      tick();
      chk("stream_beat", {mst_q_valid, slv_q_ready, mst_q_addr, mst_q_data},
          {1'b1, 1'b1, 32'h1000 + i, ~(32'h1000 + i)});
    end
    slv_q_valid = 1'b0;
    tick();
    chk("stream_end", mst_q_valid, 1'b0);

    // ---------------- response ----------------
    slv_p_ready = 1'b1;
    mst_p_data  = 32'h1234_5678; mst_p_error = 1'b1; mst_p_valid = 1'b1;
    #1;
    chk("rsp_no_comb_path", slv_p_valid, 1'b0);
    tick();
    mst_p_valid = 1'b0;
    chk("rsp_beat", {slv_p_valid, slv_p_data, slv_p_error}, {1'b1, 32'h1234_5678, 1'b1});
    tick();
    chk("rsp_drained", slv_p_valid, 1'b0);

    // response back-pressure: two beats fill both slots
    slv_p_ready = 1'b0;
    mst_p_valid = 1'b1; mst_p_data = 32'hA; mst_p_error = 1'b0;
    tick();
    mst_p_data = 32'hB; mst_p_error = 1'b1;
    tick();
    mst_p_valid = 1'b0;
    chk("rsp_bp_full", mst_p_ready, 1'b0);
    chk("rsp_bp_head", {slv_p_data, slv_p_error}, {32'hA, 1'b0});
    slv_p_ready = 1'b1;
    tick();
    chk("rsp_bp_second", {slv_p_valid, slv_p_data, slv_p_error}, {1'b1, 32'hB, 1'b1});
    tick();
    chk("rsp_bp_empty", slv_p_valid, 1'b0);

    // ---------------- async reset mid-operation ----------------
    mst_q_ready = 1'b0; slv_p_ready = 1'b0;
    slv_q_valid = 1'b1; slv_q_addr = 32'h55;
    mst_p_valid = 1'b1; mst_p_data = 32'h66;
    tick();
    slv_q_valid = 1'b0; mst_p_valid = 1'b0;
    chk("mid_loaded", {mst_q_valid, slv_p_valid}, 2'b11);
    #2 rst_n = 1'b1;                          // between clock edges
    #1;
    chk("mid_rst_valids", {mst_q_valid, slv_p_valid}, 2'b00);
    chk("mid_rst_readys", {slv_q_ready, mst_p_ready}, 2'b11);
    chk("mid_rst_data",   {mst_q_addr, slv_p_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_after", {mst_q_valid, slv_p_valid}, 2'b00);

    // ---------------- mixed traffic with scoreboard ----------------
    q_acc = 1'b0; p_acc = 1'b0;
    slv_q_valid = 1'b0; mst_p_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // masters change payload only once the previous beat is taken
      if (!slv_q_valid || q_acc) begin
        slv_q_valid = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        slv_q_addr  = $urandom;
        slv_q_data  = $urandom;
      end
      if (!mst_p_valid || p_acc) begin
        mst_p_valid = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
        mst_p_data  = $urandom;
        mst_p_error = 1'($urandom_range(0, 1));
      end
      mst_q_ready = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      slv_p_ready = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      q_acc = slv_q_valid && slv_q_ready;
      q_out = mst_q_valid && mst_q_ready;
      p_acc = mst_p_valid && mst_p_ready;
      p_out = slv_p_valid && slv_p_ready;
      if (q_out) begin
        chk("sb_q_underflow", q_exp.size() > 0, 1'b1);
        if (q_exp.size() > 0) begin
          q_front = q_exp.pop_front();
          chk("sb_q_beat", {mst_q_addr, mst_q_data}, q_front);
        end
      end
      if (p_out) begin
        chk("sb_p_underflow", p_exp.size() > 0, 1'b1);
        if (p_exp.size() > 0) begin
          p_front = p_exp.pop_front();
          chk("sb_p_beat", {slv_p_data, slv_p_error}, p_front);
        end
      end
      if (q_acc) q_exp.push_back({slv_q_addr, slv_q_data});
      if (p_acc) p_exp.push_back({mst_p_data, mst_p_error});
      tick();
    end
    chk("sb_q_empty", q_exp.size(), 0);
    chk("sb_p_empty", p_exp.size(), 0);
    chk("sb_idle", {mst_q_valid, slv_p_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
